fft_frame_ctrl: RTL and testbench
=================================

# fft_frame_ctrl

Frame sequencer in front of the radix-2 DIF FFT kernel chain. Accepts one complex sample per handshake beat and issues (even, odd) sample pairs to the first kernel stage as `en` pulses. Drains the chain with zero pairs after the last sample, and tags the result pairs coming out of the last stage with index and frame markers. Runs one N-point frame at a time. Framing and drain errors are reported on a sticky flag.

## Interface
Parameters:
- `N`, 8: FFT points; power of two, ≥4. Localparam `W = $clog2(N)`.
- `DRAIN_MAX`, 64: maximum drain beats per frame before timeout, ≥1.

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rstn_i`  in  1  reset; asynchronous, active-low.
- `s_valid_i`  in  1  input sample valid.
- `s_ready_o`  out  1  input sample ready.
- `s_real_i` / `s_imag_i`  in  16 each  signed input sample.
- `s_last_i`  in  1  marks sample N-1 of the frame.
- `k_en_o`  out  1  pair strobe to the first kernel stage.
- `k_x1_real_o` / `k_x1_imag_o` / `k_x2_real_o` / `k_x2_imag_o`  out  16 each  signed pair to the kernel.
- `k_valid_i`  in  1  result pair valid from the last kernel stage.
- `k_X1_real_i` / `k_X1_imag_i` / `k_X2_real_i` / `k_X2_imag_i`  in  16 each  signed result pair.
- `m_valid_o`  out  1  output pair valid.
- `m_X1_real_o` / `m_X1_imag_o` / `m_X2_real_o` / `m_X2_imag_o`  out  16 each  registered result pair.
- `m_idx_o`  out  W-1  result pair index.
- `m_sof_o` / `m_eof_o`  out  1 each  first / last pair of frame.
- `done_o`  out  1  one-cycle pulse at frame completion.
- `err_o`  out  1  sticky error.
- `err_clr_i`  in  1  synchronous clear of `err_o`.

## Operation
- Reset values: all outputs 0, state IDLE, all counters 0.
- State IDLE:
  - `s_ready_o`=1.
  - First accepted beat: go to LOAD, in-count becomes 1.
- State LOAD:
  - `s_ready_o`=1.
  - Even-indexed beat: captured into a hold register.
  - Odd-indexed beat: issues a pair with x1=hold, x2=current beat.
  - Accepted beat N-1: go to FLUSH.
  - `s_last_i` must be 1 on beat N-1 and 0 elsewhere. Any mismatch sets `err_o`; the frame length stays N regardless.
- State FLUSH:
  - `s_ready_o`=0.
  - `k_en_o`=1 each cycle with zero data while the out-count is below N/2 and the drain count is below `DRAIN_MAX`.
  - Drain count reaches `DRAIN_MAX` before N/2 results: set `err_o`, go to IDLE with no `done_o`.
- Result counting:
  - Out-count increments on every `k_valid_i`, in LOAD or FLUSH.
  - Out-count reaching N/2: pulse `done_o`, go to IDLE, clear all counters.
  - `k_valid_i` in IDLE sets `err_o`; no `m_valid_o` is produced for that beat.
- Output tagging:
  - `m_idx_o` = out-count before increment.
  - `m_sof_o` asserted when idx=0.
  - `m_eof_o` asserted when idx=N/2-1.
- Arithmetic: data passes through unmodified (no scaling, no saturation). Counters are W+1 bits wide; the drain counter is `$clog2(DRAIN_MAX+1)` bits. No counter wraps.
- Error flag: `err_clr_i` clears `err_o`. When a new error and `err_clr_i` occur in the same cycle, the error wins.

## Timing
- Pair issue: `k_en_o` and the pair data are registered. They assert the cycle after the odd beat's handshake and last exactly one cycle.
- The last sample pair and the first drain beat are back-to-back: FLUSH drain starts the cycle after the final pair strobe.
- Results: `m_*` is the registered copy of `k_*`, with 1-cycle latency. `done_o` asserts in the same cycle as `m_eof_o`.
- Back-to-back frames: `s_ready_o` returns to 1 the cycle after `done_o`. No input beat is accepted while `done_o` is high.
- Source stall inside LOAD (`s_valid_i`=0) holds state; the hold register keeps its value.
- Asynchronous reset mid-frame aborts: the state returns to IDLE, all outputs go to 0, and `err_o` is cleared.

## Configuration
- `FFT_CTRL_BITREV_EN` defined: `m_idx_o` is the bit-reversal of the (W-1)-bit out-count, i.e. the natural pair order of the DIF output.
- Not defined: `m_idx_o` is the raw arrival order.
- No other behaviour differs between the two builds.

## Test plan
- Nominal frame (N=8): samples 1..8 sent back-to-back with `s_last_i` on sample 8.
  - Required: `k_en_o` pulses carry (1,2), (3,4), (5,6), (7,8), then zero pairs.
  - The kernel model returns 4 `k_valid_i`; `m_idx_o` is 0,1,2,3; `m_sof_o` on idx 0, `m_eof_o` and `done_o` on idx 3; `err_o`=0.
- Bit-reversal build with `FFT_CTRL_BITREV_EN`, same stimulus: `m_idx_o` sequence is 0,2,1,3.
- Framing errors: `s_last_i` on sample 5, then again on a frame with no `s_last_i`.
  - Required: `err_o`=1 from the cycle after the bad beat, and each frame still accepts exactly 8 samples.
  - `err_clr_i` pulse then clears `err_o`.
- Drain timeout: `DRAIN_MAX`=4, kernel model returns only 2 results.
  - Required: exactly 4 drain `k_en_o` pulses, `err_o`=1, no `done_o`, state back to IDLE (`s_ready_o`=1).
- Stalls and reset:
  - Random gaps on `s_valid_i` still produce identical pairs.
  - `rstn_i` low after 5 samples: all outputs go to 0 immediately; the next frame behaves as nominal.
- Stray result: `k_valid_i` pulsed while IDLE produces `err_o`=1 and `m_valid_o`=0.

Source files
------------

// File: rtl/fft_frame_ctrl_if.sv
// Sample, kernel and result buses of the FFT frame sequencer.
// slave = sequencer side, master = source/kernel/sink side.
interface fft_frame_ctrl_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  // Sample input: a beat transfers on a rising clock edge where s_valid_i
  // and s_ready_o are both 1; the source holds data and s_last_i stable
  // while s_valid_i is high and s_ready_o is low.
  logic               s_valid_i;
  logic               s_ready_o;
  logic signed [15:0] s_real_i;
  logic signed [15:0] s_imag_i;
  logic               s_last_i;

  logic               k_en_o;
  logic signed [15:0] k_x1_real_o;
  logic signed [15:0] k_x1_imag_o;
  logic signed [15:0] k_x2_real_o;
  logic signed [15:0] k_x2_imag_o;

  logic               k_valid_i;
  logic signed [15:0] k_X1_real_i;
  logic signed [15:0] k_X1_imag_i;
  logic signed [15:0] k_X2_real_i;
  logic signed [15:0] k_X2_imag_i;

  logic               m_valid_o;
  logic signed [15:0] m_X1_real_o;
  logic signed [15:0] m_X1_imag_o;
  logic signed [15:0] m_X2_real_o;
  logic signed [15:0] m_X2_imag_o;
  logic [W-2:0]       m_idx_o;
  logic               m_sof_o;
  logic               m_eof_o;
  logic               done_o;
  logic               err_o;
  logic               err_clr_i;
  logic [1:0]         dbg_state_o;

  modport slave (
    input  s_valid_i, s_real_i, s_imag_i, s_last_i,
    input  k_valid_i, k_X1_real_i, k_X1_imag_i, k_X2_real_i, k_X2_imag_i,
    input  err_clr_i,
    output s_ready_o, k_en_o, k_x1_real_o, k_x1_imag_o, k_x2_real_o, k_x2_imag_o,
    output m_valid_o, m_X1_real_o, m_X1_imag_o, m_X2_real_o, m_X2_imag_o,
    output m_idx_o, m_sof_o, m_eof_o, done_o, err_o, dbg_state_o
  );

  modport master (
    output s_valid_i, s_real_i, s_imag_i, s_last_i,
    output k_valid_i, k_X1_real_i, k_X1_imag_i, k_X2_real_i, k_X2_imag_i,
    output err_clr_i,
    input  s_ready_o, k_en_o, k_x1_real_o, k_x1_imag_o, k_x2_real_o, k_x2_imag_o,
    input  m_valid_o, m_X1_real_o, m_X1_imag_o, m_X2_real_o, m_X2_imag_o,
    input  m_idx_o, m_sof_o, m_eof_o, done_o, err_o, dbg_state_o
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the radix-2 DIF kernel chain: pairs samples, drains, tags results.
// FFT_CTRL_BITREV_EN defined: m_idx_o is the bit-reversed result count (natural DIF order).
module fft_frame_ctrl #(
  parameter int N         = 8,
  parameter int DRAIN_MAX = 64
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  fft_frame_ctrl_if.slave bus
);
  localparam int W  = $clog2(N);
  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam logic [W:0]    HALF     = (W+1)'(N / 2);
  localparam logic [W:0]    HALF_M1  = (W+1)'(N / 2 - 1);
  localparam logic [W:0]    LAST_IDX = (W+1)'(N - 1);
  localparam logic [DW-1:0] DMAX     = DW'(DRAIN_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [W:0]         in_cnt_q, in_cnt_d;
  logic [W:0]         out_cnt_q, out_cnt_d;
  logic [DW-1:0]      drain_cnt_q, drain_cnt_d;
  logic signed [15:0] hold_re_q, hold_re_d, hold_im_q, hold_im_d;
  logic               s_ready_q, s_ready_d;
  logic               k_en_q, k_en_d;
  logic signed [15:0] k_x1_re_q, k_x1_re_d, k_x1_im_q, k_x1_im_d;
  logic signed [15:0] k_x2_re_q, k_x2_re_d, k_x2_im_q, k_x2_im_d;
  logic               m_valid_q, m_valid_d;
  logic signed [15:0] m_x1_re_q, m_x1_re_d, m_x1_im_q, m_x1_im_d;
  logic signed [15:0] m_x2_re_q, m_x2_re_d, m_x2_im_q, m_x2_im_d;
  logic [W-2:0]       m_idx_q, m_idx_d;
  logic               m_sof_q, m_sof_d, m_eof_q, m_eof_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               beat, res, timeout, err_set;
  logic [W-2:0]       idx_map;

  assign beat    = bus.s_valid_i & s_ready_q;
  assign res     = bus.k_valid_i & (state_q != ST_IDLE);
  assign timeout = (state_q == ST_FLUSH) && (out_cnt_q < HALF) && (drain_cnt_q >= DMAX);

`ifdef FFT_CTRL_BITREV_EN
  always_comb begin
    idx_map = '0;
    for (int i = 0; i < W - 1; i++) idx_map[i] = out_cnt_q[W-2-i];
  end
`else
  assign idx_map = out_cnt_q[W-2:0];
`endif

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    drain_cnt_d = drain_cnt_q;
    hold_re_d   = hold_re_q;
    hold_im_d   = hold_im_q;
    k_en_d      = 1'b0;
    k_x1_re_d   = '0;
    k_x1_im_d   = '0;
    k_x2_re_d   = '0;
    k_x2_im_d   = '0;
    m_valid_d   = 1'b0;
    m_x1_re_d   = m_x1_re_q;
    m_x1_im_d   = m_x1_im_q;
    m_x2_re_d   = m_x2_re_q;
    m_x2_im_d   = m_x2_im_q;
    m_idx_d     = m_idx_q;
    m_sof_d     = 1'b0;
    m_eof_d     = 1'b0;
    done_d      = 1'b0;
    err_set     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          hold_re_d = bus.s_real_i;
          hold_im_d = bus.s_imag_i;
          in_cnt_d  = (W+1)'(1);
          state_d   = ST_LOAD;
          if (bus.s_last_i) err_set = 1'b1;
        end
        if (bus.k_valid_i) err_set = 1'b1;
      end
      ST_LOAD: begin
        if (beat) begin
          // Framing is counted, not taken from s_last_i; a mismatch only flags.
          if (bus.s_last_i != (in_cnt_q == LAST_IDX)) err_set = 1'b1;
          if (in_cnt_q[0]) begin
            k_en_d    = 1'b1;
            k_x1_re_d = hold_re_q;
            k_x1_im_d = hold_im_q;
            k_x2_re_d = bus.s_real_i;
            k_x2_im_d = bus.s_imag_i;
          end else begin
            hold_re_d = bus.s_real_i;
            hold_im_d = bus.s_imag_i;
          end
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == LAST_IDX) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (timeout) begin
          err_set     = 1'b1;
          state_d     = ST_IDLE;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          drain_cnt_d = '0;
        end else if (out_cnt_q < HALF) begin
          k_en_d      = 1'b1;
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (res) begin
      m_valid_d = 1'b1;
      m_x1_re_d = bus.k_X1_real_i;
      m_x1_im_d = bus.k_X1_imag_i;
      m_x2_re_d = bus.k_X2_real_i;
      m_x2_im_d = bus.k_X2_imag_i;
      m_idx_d   = idx_map;
      m_sof_d   = (out_cnt_q == '0);
      m_eof_d   = (out_cnt_q == HALF_M1);
      if (!timeout) out_cnt_d = out_cnt_q + 1'b1;
      if (out_cnt_q == HALF_M1) begin
        done_d      = 1'b1;
        state_d     = ST_IDLE;
        in_cnt_d    = '0;
        out_cnt_d   = '0;
        drain_cnt_d = '0;
        k_en_d      = 1'b0;
      end
    end

    // Ready follows the next state, held low for the cycle done_o is high.
    s_ready_d = ((state_d == ST_IDLE) && !done_d) || (state_d == ST_LOAD);
    err_d     = err_set ? 1'b1 : (bus.err_clr_i ? 1'b0 : err_q);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      drain_cnt_q <= '0;
      hold_re_q   <= '0;
      hold_im_q   <= '0;
      s_ready_q   <= 1'b0;
      k_en_q      <= 1'b0;
      k_x1_re_q   <= '0;
      k_x1_im_q   <= '0;
      k_x2_re_q   <= '0;
      k_x2_im_q   <= '0;
      m_valid_q   <= 1'b0;
      m_x1_re_q   <= '0;
      m_x1_im_q   <= '0;
      m_x2_re_q   <= '0;
      m_x2_im_q   <= '0;
      m_idx_q     <= '0;
      m_sof_q     <= 1'b0;
      m_eof_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      hold_re_q   <= hold_re_d;
      hold_im_q   <= hold_im_d;
      s_ready_q   <= s_ready_d;
      k_en_q      <= k_en_d;
      k_x1_re_q   <= k_x1_re_d;
      k_x1_im_q   <= k_x1_im_d;
      k_x2_re_q   <= k_x2_re_d;
      k_x2_im_q   <= k_x2_im_d;
      m_valid_q   <= m_valid_d;
      m_x1_re_q   <= m_x1_re_d;
      m_x1_im_q   <= m_x1_im_d;
      m_x2_re_q   <= m_x2_re_d;
      m_x2_im_q   <= m_x2_im_d;
      m_idx_q     <= m_idx_d;
      m_sof_q     <= m_sof_d;
      m_eof_q     <= m_eof_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.s_ready_o   = s_ready_q;
  assign bus.k_en_o      = k_en_q;
  assign bus.k_x1_real_o = k_x1_re_q;
  assign bus.k_x1_imag_o = k_x1_im_q;
  assign bus.k_x2_real_o = k_x2_re_q;
  assign bus.k_x2_imag_o = k_x2_im_q;
  assign bus.m_valid_o   = m_valid_q;
  assign bus.m_X1_real_o = m_x1_re_q;
  assign bus.m_X1_imag_o = m_x1_im_q;
  assign bus.m_X2_real_o = m_x2_re_q;
  assign bus.m_X2_imag_o = m_x2_im_q;
  assign bus.m_idx_o     = m_idx_q;
  assign bus.m_sof_o     = m_sof_q;
  assign bus.m_eof_o     = m_eof_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.dbg_state_o = state_q;
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: sample driver, kernel model with
// fixed latency, and scoreboards for issued pairs and tagged results.
module tb_fft_frame_ctrl;
  localparam int N         = 8;
  localparam int DRAIN_MAX = 4;
  localparam int L         = 3;
  localparam int IW        = $clog2(N) - 1;

  // clock / reset
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fft_frame_ctrl_if #(.N(N)) bus();

  fft_frame_ctrl #(.N(N), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int exp_err = 0;
  int drain_seen = 0;
  int done_seen = 0;
  int kern_budget = 4;
  int kern_taken = 0;
  bit stray_req = 1'b0;

  logic [63:0] pair_q[$];
  logic [67:0] exp_q[$];   // {X1r, X1i, X2r, X2i, idx, sof, eof}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] exp_idx(input int k);
    logic [IW-1:0] v, r;
    v = IW'(k);
    r = v;
`ifdef FFT_CTRL_BITREV_EN
    for (int i = 0; i < IW; i++) r[i] = v[IW-1-i];
`endif
    return r;
  endfunction

  // Kernel model: the first min(budget, N/2) strobes of a frame each return
  // (x1+x2, x1-x2) after L cycles.
  logic        pv[L];
  logic [63:0] pd[L];
  always @(negedge clk) begin : kern_model
    logic [15:0] ar, ai, br, bi;
    if (!rstn) begin
      for (int i = 0; i < L; i++) begin pv[i] = 1'b0; pd[i] = '0; end
      bus.k_valid_i = 1'b0;
      {bus.k_X1_real_i, bus.k_X1_imag_i, bus.k_X2_real_i, bus.k_X2_imag_i} = '0;
    end else begin
      bus.k_valid_i = pv[L-1] | stray_req;
      {bus.k_X1_real_i, bus.k_X1_imag_i, bus.k_X2_real_i, bus.k_X2_imag_i} =
        stray_req ? 64'h0123_4567_89ab_cdef : pd[L-1];
      stray_req = 1'b0;
      for (int i = L - 1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
      pv[0] = 1'b0;
      if (bus.k_en_o && kern_taken < kern_budget && kern_taken < N / 2) begin
        {ar, ai, br, bi} = {bus.k_x1_real_o, bus.k_x1_imag_o, bus.k_x2_real_o, bus.k_x2_imag_o};
        pv[0] = 1'b1;
        pd[0] = {16'(ar + br), 16'(ai + bi), 16'(ar - br), 16'(ai - bi)};
        exp_q.push_back({pd[0], exp_idx(kern_taken), kern_taken == 0, kern_taken == N / 2 - 1});
        kern_taken++;
      end
    end
  end

  // Monitors: pair strobes and tagged results.
  always @(negedge clk) begin : monitor
    logic [67:0] e;
    if (rstn) begin
      if (bus.k_en_o) begin
        if (pair_q.size() > 0)
          check("pair", {bus.k_x1_real_o, bus.k_x1_imag_o, bus.k_x2_real_o, bus.k_x2_imag_o},
                pair_q.pop_front());
        else begin
          check("drain_zero", {bus.k_x1_real_o, bus.k_x1_imag_o, bus.k_x2_real_o, bus.k_x2_imag_o},
                64'd0);
          drain_seen++;
        end
      end
      if (bus.m_valid_o) begin
        if (exp_q.size() == 0) check("m_unexp", 64'(bus.m_valid_o), 64'd0);
        else begin
          e = exp_q.pop_front();
          check("m_data", {bus.m_X1_real_o, bus.m_X1_imag_o, bus.m_X2_real_o, bus.m_X2_imag_o},
                e[67:4]);
          check("m_idx", 64'(bus.m_idx_o), 64'(e[3:2]));
          check("m_sof", 64'(bus.m_sof_o), 64'(e[1]));
          check("m_eof", 64'(bus.m_eof_o), 64'(e[0]));
          check("m_done", 64'(bus.done_o), 64'(e[0]));
        end
      end else if (bus.done_o) check("done_no_valid", 64'(bus.done_o), 64'd0);
      if (bus.done_o) begin
        done_seen++;
        check("rdy_at_done", 64'(bus.s_ready_o), 64'd0);
      end
    end
  end

  // driver tasks
  task automatic send_beat(input logic [15:0] re, input logic [15:0] im, input bit last);
    int n = 0;
    @(negedge clk);
    bus.s_valid_i = 1'b1;
    bus.s_real_i  = re;
    bus.s_imag_i  = im;
    bus.s_last_i  = last;
    while (!bus.s_ready_o && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("beat_timeout", 64'(bus.s_ready_o), 64'd1);
    @(posedge clk);
    #1;
    bus.s_valid_i = 1'b0;
    bus.s_last_i  = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk);
    bus.err_clr_i = 1'b1;
    @(negedge clk);
    bus.err_clr_i = 1'b0;
    exp_err = 0;
    check("err_clr", 64'(bus.err_o), 64'd0);
  endtask

  task automatic abort_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("ar_ready", 64'(bus.s_ready_o), 64'd0);
    check("ar_k_en", 64'(bus.k_en_o), 64'd0);
    check("ar_m_valid", 64'(bus.m_valid_o), 64'd0);
    check("ar_done", 64'(bus.done_o), 64'd0);
    check("ar_err", 64'(bus.err_o), 64'd0);
    check("ar_pair", {bus.k_x1_real_o, bus.k_x1_imag_o, bus.k_x2_real_o, bus.k_x2_imag_o}, 64'd0);
    pair_q.delete();
    exp_q.delete();
    exp_err = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // last_pos: beat carrying s_last_i (-1 none); abort_after: reset after that many beats (-1 none)
  task automatic run_frame(input bit seq, input int last_pos, input int gap_max,
                           input int budget, input int abort_after);
    logic [15:0] re[N], im[N];
    int bad, n;
    for (int i = 0; i < N; i++) begin
      re[i] = seq ? 16'(i + 1) : 16'($urandom);
      im[i] = seq ? 16'(100 + i) : 16'($urandom);
    end
    kern_taken  = 0;
    kern_budget = budget;
    drain_seen  = 0;
    done_seen   = 0;
    for (int p = 0; p < N / 2; p++)
      pair_q.push_back({re[2*p], im[2*p], re[2*p+1], im[2*p+1]});
    bad = (last_pos == N - 1) ? -1 : ((last_pos >= 0) ? last_pos : N - 1);
    for (int i = 0; i < N; i++) begin
      if (abort_after == i) begin
        abort_reset();
        return;
      end
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_beat(re[i], im[i], i == last_pos);
      if (i == bad) begin
        exp_err = 1;
        check("err_set", 64'(bus.err_o), 64'd1);
      end
    end
    @(negedge clk);
    check("len_ready_low", 64'(bus.s_ready_o), 64'd0);
    n = 0;
    while (!bus.s_ready_o && n < 200) begin @(negedge clk); n++; end
    check("frame_end_timeout", 64'(n < 200), 64'd1);
    if (budget < N / 2) begin
      exp_err = 1;
      check("drain_count", 64'(drain_seen), 64'(DRAIN_MAX));
      check("done_count", 64'(done_seen), 64'd0);
    end else begin
      check("done_count", 64'(done_seen), 64'd1);
      check("drain_bound", 64'(drain_seen <= DRAIN_MAX), 64'd1);
    end
    check("pairs_left", 64'(pair_q.size()), 64'd0);
    check("results_left", 64'(exp_q.size()), 64'd0);
    check("err_end", 64'(bus.err_o), 64'(exp_err));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid_i = 1'b0;
    bus.s_real_i  = '0;
    bus.s_imag_i  = '0;
    bus.s_last_i  = 1'b0;
    bus.err_clr_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.s_ready_o), 64'd0);
    check("rst_k_en", 64'(bus.k_en_o), 64'd0);
    check("rst_m_valid", 64'(bus.m_valid_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_err", 64'(bus.err_o), 64'd0);
    check("rst_idx", 64'(bus.m_idx_o), 64'd0);
    rstn = 1'b1;

    run_frame(1'b1, N - 1, 0, 4, -1);   // nominal 1..8
    run_frame(1'b0, 4, 0, 4, -1);       // s_last_i early
    clear_err();
    run_frame(1'b0, -1, 0, 4, -1);      // s_last_i missing
    clear_err();
    run_frame(1'b0, N - 1, 0, 2, -1);   // drain timeout
    clear_err();
    run_frame(1'b1, N - 1, 3, 4, -1);   // stalled source
    run_frame(1'b0, N - 1, 2, 4, -1);

    // stray result while idle
    @(posedge clk);
    #1 stray_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_err = 1;
    check("stray_err", 64'(bus.err_o), 64'd1);
    check("stray_m_valid", 64'(bus.m_valid_o), 64'd0);

    run_frame(1'b1, N - 1, 0, 4, 5);    // reset after 5 samples
    run_frame(1'b1, N - 1, 0, 4, -1);   // nominal after reset

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
